// File: rtl/periph_arbiter.sv
// Two-master (instruction/data) to three-slave (RAM/UART/CLINT) bus arbiter.
// Ports:
//   clock, reset                  rising-edge clock, async active-low reset
//   imem_in/imem_out              instruction master request/response
//   dmem_in/dmem_out              data master request/response (higher priority)
//   ram_in/uart_in/clint_in       slave requests (offset addresses)
//   ram_out/uart_out/clint_out    slave responses
package periph_arbiter_pkg;
    typedef struct packed {
        logic        mem_valid;
        logic [31:0] mem_addr;
        logic [31:0] mem_wdata;
        logic [3:0]  mem_wstrb;
    } mem_in_type;

    typedef struct packed {
        logic        mem_ready;
        logic        mem_error;
        logic [31:0] mem_rdata;
    } mem_out_type;
endpackage

module periph_arbiter
    import periph_arbiter_pkg::*;
#(
    parameter logic [31:0] ram_base   = 32'h0000_0000,
    parameter logic [31:0] ram_size   = 32'h0010_0000,
    parameter logic [31:0] uart_base  = 32'h0100_0000,
    parameter logic [31:0] uart_size  = 32'h0000_1000,
    parameter logic [31:0] clint_base = 32'h0200_0000,
    parameter logic [31:0] clint_size = 32'h0001_0000,
    parameter int unsigned timeout    = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  mem_in_type  imem_in,
    output mem_out_type imem_out,
    input  mem_in_type  dmem_in,
    output mem_out_type dmem_out,
    output mem_in_type  ram_in,
    output mem_in_type  uart_in,
    output mem_in_type  clint_in,
    input  mem_out_type ram_out,
    input  mem_out_type uart_out,
    input  mem_out_type clint_out
);
    localparam int unsigned cnt_w = $clog2(timeout + 1);
    localparam logic [cnt_w-1:0] cnt_last = cnt_w'(timeout - 1);

    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic [1:0] {SEL_RAM, SEL_UART, SEL_CLINT} sel_t;

    state_t           state, state_n;
    sel_t             sel, sel_n;
    logic             owner, owner_n;      // 1: data master owns the transaction
    logic [cnt_w-1:0] cnt, cnt_n;
    logic [1:0]       pend_v, pend_v_n, acc, eff_v;
    mem_in_type       pend_q [2];
    mem_in_type       pend_n [2];
    mem_in_type       m_in [2];
    mem_in_type       grant;
    mem_in_type       ram_n, uart_n, clint_n;
    mem_out_type      imem_n, dmem_n, rsp, sel_rsp;
    logic             rsp_v, g;

    // Region hit in 33 bits so base+size never wraps.
    function automatic logic in_region(input logic [31:0] a, input logic [31:0] base,
                                       input logic [31:0] size);
        logic [32:0] x, lo, hi;
        x  = {1'b0, a};
        lo = {1'b0, base};
        hi = lo + {1'b0, size};
        return (x >= lo) && (x < hi);
    endfunction

    // Capture, arbitration, decode, wait/timeout and response steering.
    always_comb begin
        state_n  = state;
        sel_n    = sel;
        owner_n  = owner;
        cnt_n    = cnt;
        ram_n    = '0;
        uart_n   = '0;
        clint_n  = '0;
        imem_n   = '0;
        dmem_n   = '0;
        rsp      = '0;
        rsp_v    = 1'b0;
        g        = 1'b0;
        grant    = '0;
        sel_rsp  = '0;
        m_in[0]  = imem_in;
        m_in[1]  = dmem_in;

        // A pulse is taken only when that master has nothing pending or in flight.
        for (int m = 0; m < 2; m++) begin
            acc[m]    = m_in[m].mem_valid && !pend_v[m] && !(state == WAIT && owner == 1'(m));
            pend_n[m] = acc[m] ? m_in[m] : pend_q[m];
            eff_v[m]  = pend_v[m] || acc[m];
        end
        pend_v_n = pend_v | acc;

        case (sel)
            SEL_RAM:   sel_rsp = ram_out;
            SEL_UART:  sel_rsp = uart_out;
            SEL_CLINT: sel_rsp = clint_out;
            default:   sel_rsp = '0;
        endcase

        case (state)
            IDLE: begin
                if (|eff_v) begin
                    g           = eff_v[1];
                    grant       = pend_n[g];
                    pend_v_n[g] = 1'b0;
                    owner_n     = g;
                    cnt_n       = '0;
                    if (in_region(grant.mem_addr, ram_base, ram_size)) begin
                        ram_n           = grant;
                        ram_n.mem_valid = 1'b1;
                        ram_n.mem_addr  = grant.mem_addr - ram_base;
                        sel_n           = SEL_RAM;
                        state_n         = WAIT;
                    end else if (in_region(grant.mem_addr, uart_base, uart_size)) begin
                        uart_n           = grant;
                        uart_n.mem_valid = 1'b1;
                        uart_n.mem_addr  = grant.mem_addr - uart_base;
                        sel_n            = SEL_UART;
                        state_n          = WAIT;
                    end else if (in_region(grant.mem_addr, clint_base, clint_size)) begin
                        clint_n           = grant;
                        clint_n.mem_valid = 1'b1;
                        clint_n.mem_addr  = grant.mem_addr - clint_base;
                        sel_n             = SEL_CLINT;
                        state_n           = WAIT;
                    end else begin
                        rsp_v         = 1'b1;
                        rsp.mem_ready = 1'b1;
                        rsp.mem_error = 1'b1;
                    end
                end
            end
            WAIT: begin
                // A slave answer in the final count cycle still wins over the timeout.
                if (sel_rsp.mem_ready) begin
                    rsp_v   = 1'b1;
                    rsp     = sel_rsp;
                    state_n = IDLE;
                end else if (cnt == cnt_last) begin
                    rsp_v         = 1'b1;
                    rsp.mem_ready = 1'b1;
                    rsp.mem_error = 1'b1;
                    state_n       = IDLE;
                end else begin
                    cnt_n = cnt + cnt_w'(1);
                end
            end
            default: state_n = IDLE;
        endcase

        if (rsp_v) begin
            if (owner_n) dmem_n = rsp;
            else         imem_n = rsp;
        end
    end

    // State and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sel       <= SEL_RAM;
            owner     <= 1'b0;
            cnt       <= '0;
            pend_v    <= '0;
            pend_q[0] <= '0;
            pend_q[1] <= '0;
            ram_in    <= '0;
            uart_in   <= '0;
            clint_in  <= '0;
            imem_out  <= '0;
            dmem_out  <= '0;
        end else begin
            state     <= state_n;
            sel       <= sel_n;
            owner     <= owner_n;
            cnt       <= cnt_n;
            pend_v    <= pend_v_n;
            pend_q[0] <= pend_n[0];
            pend_q[1] <= pend_n[1];
            ram_in    <= ram_n;
            uart_in   <= uart_n;
            clint_in  <= clint_n;
            imem_out  <= imem_n;
            dmem_out  <= dmem_n;
        end
    end
endmodule

// File: doc/periph_arbiter.md
PERIPH_ARBITER -- requirements
Module: periph_arbiter

Interface
REQ-001 SHALL have parameter ram_base, default 32'h0000_0000, RAM region base.
REQ-002 SHALL have parameter ram_size, default 32'h0010_0000, RAM region size in bytes.
REQ-003 SHALL have parameter uart_base, default 32'h0100_0000, UART region base.
REQ-004 SHALL have parameter uart_size, default 32'h0000_1000, UART region size.
REQ-005 SHALL have parameter clint_base, default 32'h0200_0000, timer block region base.
REQ-006 SHALL have parameter clint_size, default 32'h0001_0000, timer block region size.
REQ-007 SHALL have parameter timeout, default 1024, maximum slave wait in cycles (>=2).
REQ-008 SHALL have port clock, input, 1, sole clock; all state on its rising edge.
REQ-009 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-010 SHALL have ports imem_in (input, mem_in_type) and imem_out (output, mem_out_type): instruction master.
REQ-011 SHALL have ports dmem_in (input, mem_in_type) and dmem_out (output, mem_out_type): data master.
REQ-012 SHALL have ports ram_in, uart_in, clint_in (output, mem_in_type), one request per slave.
REQ-013 SHALL have ports ram_out, uart_out, clint_out (input, mem_out_type), one response per slave.

Function
REQ-014 SHALL treat master mem_valid as a one-cycle pulse and latch addr/wdata/wstrb into that master's pending register at the rising edge where it is seen.
REQ-015 SHALL ignore a master's mem_valid while that master already has a pending or in-flight request.
REQ-016 SHALL run a two-state FSM, IDLE and WAIT; reset state IDLE.
REQ-017 SHALL, in IDLE with any request pending, grant data master over instruction master; the loser stays pending.
REQ-018 SHALL decode the granted address as region hit iff base <= addr < base+size, computed in 33 bits so base+size cannot wrap.
REQ-019 SHALL, on a mapped hit, drive the selected slave mem_valid=1 for exactly one cycle (registered) with addr = addr-base and unchanged wdata/wstrb, clear that pending flag, and enter WAIT.
REQ-020 SHALL hold all non-selected slave mem_valid at 0 and all slave inputs at 0 when not issuing.
REQ-021 SHALL, on an unmapped address, pulse the owner's mem_ready=1, mem_error=1, mem_rdata=0 on the next cycle and remain IDLE.
REQ-022 SHALL, in WAIT, return the selected slave's mem_rdata and mem_error to the owning master with mem_ready=1 for one cycle, registered one cycle after the slave mem_ready, then return to IDLE.
REQ-023 SHALL ignore mem_ready from any non-selected slave.
REQ-024 SHALL count WAIT cycles from 0; at count timeout-1 without slave ready it SHALL pulse owner mem_ready=1, mem_error=1, mem_rdata=0, return to IDLE, and ignore a later stale ready from that slave.
REQ-025 SHALL give a mapped request latency: master valid cycle 0, slave valid cycle 1, master ready cycle N+2 for a slave answering in cycle N+1 (clint: N=1, master ready cycle 3).
REQ-026 SHALL drive master mem_ready, mem_error, mem_rdata to 0 in every cycle without a response.
REQ-027 SHALL accept a new master pulse in the same cycle its previous response is delivered and still capture it.

Reset
REQ-028 SHALL on reset=0, immediately and asynchronously, clear FSM to IDLE, both pending flags, wait counter, all slave mem_valid and all master mem_ready/mem_error/mem_rdata to 0.
REQ-029 SHALL discard any in-flight transaction on reset mid-operation; no response is delivered after reset release.

Verification
REQ-030 Data read 0x0200_BFF8 -> clint_in.mem_valid=1 cycle 1 with addr 0xBFF8, wstrb 0; dmem_out.mem_ready=1 cycle 3 with clint rdata, error 0.
REQ-031 imem and dmem pulse same cycle (RAM 0x100, UART 0x0100_0004) -> UART served first, RAM issued in the cycle after the data response, both ready exactly once.
REQ-032 Data write to 0x0300_0000 (unmapped) -> no slave valid; dmem_out ready=1, error=1, rdata=0 next cycle.
REQ-033 timeout=8, UART never ready -> error response after WAIT count 7; stale UART ready afterwards produces no master response.
REQ-034 Assert reset=0 while in WAIT -> all outputs 0 without a clock edge; after release, IDLE, no stale response.
REQ-035 Address ram_base+ram_size-1 hits RAM; ram_base+ram_size is unmapped (error response).
